// File: rtl/vid_pkg.sv
// Shared video/BRAM definitions for the frame BRAM scheduler.
// Holds the display geometry, the BRAM geometry, the port slot-state enum,
// the pixel-word field offsets and the pixel-doubled read-address helper.
package vid_pkg;

  localparam int unsigned H_ACTIVE    = 800;
  localparam int unsigned V_ACTIVE    = 600;
  localparam int unsigned LINE_WORDS  = 400;
  localparam int unsigned FRAME_WORDS = 120000;
  localparam int unsigned ADDR_W      = 18;
  localparam int unsigned DATA_W      = 6;

  // Pixel word layout {R[1:0],G[1:0],B[1:0]}
  localparam int unsigned R_LSB = 4;
  localparam int unsigned G_LSB = 2;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE
  } slot_t;

  // Each stored word covers a 2x2 block of display pixels.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic        sel,
                                                   input logic [10:0] x,
                                                   input logic [9:0]  y);
    logic [ADDR_W-1:0] base;
    base = sel ? ADDR_W'(FRAME_WORDS) : '0;
    return base + ADDR_W'(x >> 1) + ADDR_W'(y >> 1) * ADDR_W'(LINE_WORDS);
  endfunction

endpackage

// File: rtl/frame_sequencer.sv
// Frame sequencer: detects the start of vertical blank, counts displayed
// frames and toggles the displayed frame either automatically every
// FRAME_HOLD boundaries or on a pending manual request.
// Ports:
//   clk, rst          - pixel clock, async active-high reset
//   count_rgb         - horizontal counter
//   reset_count_rgb   - vertical counter
//   frame_force       - pulse: toggle at the next boundary
//   frame_sel         - frame currently displayed
module frame_sequencer
  import vid_pkg::*;
#(
  parameter int unsigned FRAME_HOLD = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] count_rgb,
  input  logic [9:0]  reset_count_rgb,
  input  logic        frame_force,
  output logic        frame_sel
);

  localparam int unsigned CNT_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((FRAME_HOLD == 0) ? 0 : FRAME_HOLD - 1);

  logic [CNT_W-1:0] frame_cnt;
  logic             pending;
  logic             boundary;

  assign boundary = (count_rgb == 11'd0) && (reset_count_rgb == 10'(V_ACTIVE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sel <= 1'b0;
      frame_cnt <= '0;
      pending   <= 1'b0;
    end else if (boundary) begin
      // A force arriving in the boundary cycle itself waits for the next one.
      pending <= frame_force;
      if (pending) begin
        // Force overrides the auto toggle so both together flip only once.
        frame_sel <= ~frame_sel;
        frame_cnt <= '0;
      end else if (FRAME_HOLD != 0) begin
        if (frame_cnt == LAST) begin
          frame_sel <= ~frame_sel;
          frame_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end else if (frame_force) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/frame_bram_scheduler.sv
// Frame BRAM scheduler: owns the single port of the shared pixel BRAM.
// Display reads (pixel-doubled address, frame base from frame_sel) take
// strict priority; host writes are served in blanking cycles only.
// Ports:
//   clk, rst                  - pixel clock, async active-high reset
//   count_rgb/reset_count_rgb - sync counters (x / y)
//   frame_force               - request a frame toggle at next boundary
//   wr_req/wr_addr/wr_data    - host write request, held until wr_ack
//   wr_ack/wr_err             - write done / rejected (address out of range)
//   bram_en/we/addr/wdata     - BRAM port, registered one cycle after counters
//   frame_sel                 - frame being displayed
//   pix_valid                 - BRAM read data holds an active pixel
module frame_bram_scheduler
  import vid_pkg::*;
#(
  parameter int unsigned FRAME_HOLD = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       count_rgb,
  input  logic [9:0]        reset_count_rgb,
  input  logic              frame_force,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              frame_sel,
  output logic              pix_valid
);

  slot_t             slot, slot_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [DATA_W-1:0] wdata_q, wdata_next;
  logic              oor_q, oor_next;
  logic              active;
  logic              wr_oor;
  logic              wr_ack_prev;

  frame_sequencer #(
    .FRAME_HOLD(FRAME_HOLD)
  ) u_seq (
    .clk             (clk),
    .rst             (rst),
    .count_rgb       (count_rgb),
    .reset_count_rgb (reset_count_rgb),
    .frame_force     (frame_force),
    .frame_sel       (frame_sel)
  );

  // State register (slot plus the port data captured with it)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot      <= SLOT_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      oor_q     <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      slot      <= slot_next;
      addr_q    <= addr_next;
      wdata_q   <= wdata_next;
      oor_q     <= oor_next;
      pix_valid <= (slot == SLOT_READ);
    end
  end

  // Next-slot decision
  always_comb begin
    active      = (count_rgb < 11'(H_ACTIVE)) && (reset_count_rgb < 10'(V_ACTIVE));
    wr_oor      = (wr_addr >= ADDR_W'(2 * FRAME_WORDS));
    // The ack is visible during the cycle this decision is made, so the
    // still-asserted request of an acked word is not served twice.
    wr_ack_prev = (slot == SLOT_WRITE);
    slot_next   = SLOT_IDLE;
    addr_next   = addr_q;
    wdata_next  = wdata_q;
    oor_next    = 1'b0;
    if (active) begin
      slot_next = SLOT_READ;
      addr_next = pixel_addr(frame_sel, count_rgb, reset_count_rgb);
    end else if (wr_req && !wr_ack_prev) begin
      slot_next = SLOT_WRITE;
      oor_next  = wr_oor;
      if (!wr_oor) begin
        addr_next  = wr_addr;
        wdata_next = wr_data;
      end
    end
  end

  // Port outputs
  always_comb begin
    bram_en    = (slot == SLOT_READ) || ((slot == SLOT_WRITE) && !oor_q);
    bram_we    = (slot == SLOT_WRITE) && !oor_q;
    wr_ack     = (slot == SLOT_WRITE);
    wr_err     = (slot == SLOT_WRITE) && oor_q;
    bram_addr  = addr_q;
    bram_wdata = wdata_q;
  end

endmodule

// File: tb/tb_frame_bram_scheduler.sv
// Self-checking bench for frame_bram_scheduler: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_frame_bram_scheduler;
  import vid_pkg::*;

  localparam int unsigned HOLD = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [10:0]       count_rgb;
  logic [9:0]        reset_count_rgb;
  logic              frame_force;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack, wr_err, bram_en, bram_we, frame_sel, pix_valid;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;

  frame_bram_scheduler #(.FRAME_HOLD(HOLD)) dut (
    .clk             (clk),
    .rst             (rst),
    .count_rgb       (count_rgb),
    .reset_count_rgb (reset_count_rgb),
    .frame_force     (frame_force),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ack          (wr_ack),
    .wr_err          (wr_err),
    .bram_en         (bram_en),
    .bram_we         (bram_we),
    .bram_addr       (bram_addr),
    .bram_wdata      (bram_wdata),
    .frame_sel       (frame_sel),
    .pix_valid       (pix_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected port contents for the cycle after each edge
  bit m_en, m_we, m_ack, m_err, m_sel, m_pv, m_read_last, m_pend;
  int m_addr, m_wdata, m_cnt;

  initial begin : model
    int x, y;
    bit act, was_ack;
    m_en = 0; m_we = 0; m_ack = 0; m_err = 0; m_sel = 0; m_pv = 0;
    m_read_last = 0; m_pend = 0; m_addr = 0; m_wdata = 0; m_cnt = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_en = 0; m_we = 0; m_ack = 0; m_err = 0; m_sel = 0; m_pv = 0;
        m_read_last = 0; m_pend = 0; m_addr = 0; m_wdata = 0; m_cnt = 0;
      end else begin
        x = int'(count_rgb);
        y = int'(reset_count_rgb);
        act = (x < 800) && (y < 600);
        was_ack = m_ack;
        m_pv = m_read_last;
        m_read_last = 0; m_en = 0; m_we = 0; m_ack = 0; m_err = 0;
        if (act) begin
          m_read_last = 1;
          m_en = 1;
          m_addr = (m_sel ? 120000 : 0) + x / 2 + (y / 2) * 400;
        end else if (wr_req && !was_ack) begin
          m_ack = 1;
          if (int'(wr_addr) >= 240000) m_err = 1;
          else begin
            m_en = 1; m_we = 1;
            m_addr = int'(wr_addr);
            m_wdata = int'(wr_data);
          end
        end
        if (x == 0 && y == 600) begin
          if (m_pend) begin
            m_sel = !m_sel; m_cnt = 0;
          end else begin
            m_cnt++;
            if (m_cnt == HOLD) begin m_sel = !m_sel; m_cnt = 0; end
          end
          m_pend = frame_force;
        end else if (frame_force) begin
          m_pend = 1;
        end
      end
    end
  end

  // Compare process, mid-cycle on the falling edge
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("cmp_en", 32'(bram_en), 0);
        chk("cmp_we", 32'(bram_we), 0);
        chk("cmp_addr", 32'(bram_addr), 0);
        chk("cmp_wdata", 32'(bram_wdata), 0);
        chk("cmp_ack", 32'(wr_ack), 0);
        chk("cmp_err", 32'(wr_err), 0);
        chk("cmp_sel", 32'(frame_sel), 0);
        chk("cmp_pv", 32'(pix_valid), 0);
      end else begin
        chk("cmp_en", 32'(bram_en), 32'(m_en));
        chk("cmp_we", 32'(bram_we), 32'(m_we));
        chk("cmp_addr", 32'(bram_addr), 32'(m_addr));
        chk("cmp_wdata", 32'(bram_wdata), 32'(m_wdata));
        chk("cmp_ack", 32'(wr_ack), 32'(m_ack));
        chk("cmp_err", 32'(wr_err), 32'(m_err));
        chk("cmp_sel", 32'(frame_sel), 32'(m_sel));
        chk("cmp_pv", 32'(pix_valid), 32'(m_pv));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y);
    count_rgb = 11'(x);
    reset_count_rgb = 10'(y);
  endtask

  task automatic new_word();
    wr_req = 1'b1;
    if ($urandom_range(0, 7) == 0) wr_addr = ADDR_W'($urandom_range(240000, 262143));
    else wr_addr = ADDR_W'($urandom_range(0, 239999));
    wr_data = DATA_W'($urandom);
  endtask

  initial begin : main
    drive(1000, 650);
    frame_force = 0; wr_req = 0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_en", 32'(bram_en), 0);
    chk("reset_addr", 32'(bram_addr), 0);
    chk("reset_sel", 32'(frame_sel), 0);
    chk("reset_pv", 32'(pix_valid), 0);
    rst = 0;

    // Read address, frame 0, and read latency
    drive(5, 3); tick();
    chk("rd_en", 32'(bram_en), 1);
    chk("rd_we", 32'(bram_we), 0);
    chk("rd_addr_f0", 32'(bram_addr), 402);
    drive(1000, 650); tick();
    chk("rd_pix_valid", 32'(pix_valid), 1);

    // Forced toggle to frame 1
    frame_force = 1; drive(900, 650); tick();
    frame_force = 0; drive(0, 600); tick();
    chk("force_sel", 32'(frame_sel), 1);
    drive(5, 3); tick();
    chk("rd_addr_f1", 32'(bram_addr), 120402);
    drive(799, 599); tick();
    chk("rd_addr_max", 32'(bram_addr), 239999);

    // Auto toggle every third boundary, stable mid-frame
    for (int k = 1; k <= 3; k++) begin
      drive(0, 600); tick();
      chk("auto_sel_bnd", 32'(frame_sel), (k < 3) ? 1 : 0);
      drive(10, 10); tick();
      chk("auto_sel_mid", 32'(frame_sel), (k < 3) ? 1 : 0);
    end

    // Force together with the auto-toggle boundary flips only once
    for (int k = 0; k < 2; k++) begin
      drive(0, 600); tick();
      drive(10, 10); tick();
    end
    frame_force = 1; drive(900, 650); tick();
    frame_force = 0; drive(0, 600); tick();
    chk("force_auto_once", 32'(frame_sel), 1);
    // Force in the boundary cycle itself is deferred to the next boundary
    drive(10, 10); tick();
    frame_force = 1; drive(0, 600); tick();
    frame_force = 0;
    chk("force_in_bnd", 32'(frame_sel), 1);
    drive(10, 10); tick();
    drive(0, 600); tick();
    chk("force_deferred", 32'(frame_sel), 0);

    // Write waits for blanking, acked once
    wr_req = 1; wr_addr = 18'd1000; wr_data = 6'h2A;
    drive(10, 10); tick();
    chk("wr_blocked_we", 32'(bram_we), 0);
    chk("wr_blocked_ack", 32'(wr_ack), 0);
    drive(11, 10); tick();
    chk("wr_blocked_we2", 32'(bram_we), 0);
    drive(800, 10); tick();
    chk("wr_we", 32'(bram_we), 1);
    chk("wr_addr", 32'(bram_addr), 1000);
    chk("wr_wdata", 32'(bram_wdata), 32'h2A);
    chk("wr_ack", 32'(wr_ack), 1);
    drive(801, 10); tick();
    chk("wr_no_repeat_we", 32'(bram_we), 0);
    chk("wr_no_repeat_ack", 32'(wr_ack), 0);
    wr_req = 0;

    // Out-of-range write is rejected
    wr_req = 1; wr_addr = 18'd240000; drive(900, 620); tick();
    chk("oor_ack", 32'(wr_ack), 1);
    chk("oor_err", 32'(wr_err), 1);
    chk("oor_en", 32'(bram_en), 0);
    wr_req = 0; drive(901, 620); tick();

    // Reset in the middle of a write
    wr_req = 1; wr_addr = 18'd77; wr_data = 6'h15;
    drive(850, 5); tick();
    chk("rstw_we_before", 32'(bram_we), 1);
    rst = 1; #1;
    chk("rstw_en", 32'(bram_en), 0);
    chk("rstw_we", 32'(bram_we), 0);
    chk("rstw_ack", 32'(wr_ack), 0);
    @(posedge clk); #1;
    rst = 0; drive(860, 5); tick();
    chk("rstw_retry_we", 32'(bram_we), 1);
    chk("rstw_retry_addr", 32'(bram_addr), 77);
    chk("rstw_retry_ack", 32'(wr_ack), 1);
    wr_req = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) drive(0, 600);
      else drive(int'($urandom_range(0, 1055)), int'($urandom_range(0, 627)));
      frame_force = ($urandom_range(0, 39) == 0);
      if (wr_ack) begin
        if ($urandom_range(0, 1) == 1) new_word();
        else wr_req = 0;
      end else if (!wr_req && $urandom_range(0, 3) == 0) begin
        new_word();
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; wr_req = 0; frame_force = 0; drive(1000, 650);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
